// File: rtl/inst_sram_responder.sv
// inst_sram_responder: responder end of the instruction-SRAM interface.
// Returns the addressed 32-bit word one cycle after each request and supports
// byte writes for preload and self-modifying code.
// Optional feature macro: INST_SRAM_ADDR_ERR_EN (registered address-error flag,
// misaligned writes suppressed). Without it inst_sram_addr_err is tied to 0.
module inst_sram_responder #(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'hbfc0_0000,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_rvalid,
  output logic        inst_sram_addr_err
);

  localparam int          DEPTH        = 1 << DEPTH_LOG2;
  localparam logic [32:0] WINDOW_BYTES = 33'(64'd4 << DEPTH_LOG2);

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [31:0]           r_rdata;
  logic                  r_rvalid;

  logic [31:0]           w_off;
  logic                  w_inRange;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_wrAllowed;

  // Addresses below BASE_ADDR wrap to a huge offset and so fall out of range.
  assign w_off     = inst_sram_addr - BASE_ADDR;
  assign w_inRange = ({1'b0, w_off} < WINDOW_BYTES);
  assign w_idx     = w_off[DEPTH_LOG2+1:2];

`ifdef INST_SRAM_ADDR_ERR_EN
  logic r_addrErr;

  assign w_wrAllowed = w_inRange & (inst_sram_addr[1:0] == 2'b00);

  // Error flag travels with rvalid: set for misaligned or unmapped requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addrErr <= 1'b0;
    end else begin
      r_addrErr <= inst_sram_en & ((inst_sram_addr[1:0] != 2'b00) | ~w_inRange);
    end
  end

  assign inst_sram_addr_err = r_addrErr;
`else
  assign w_wrAllowed        = w_inRange;
  assign inst_sram_addr_err = 1'b0;
`endif

  // Read-first response registers plus byte writes; the store shares the
  // reset-qualified block so a write is dropped whenever reset is low at the
  // edge, while its contents are deliberately never cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= inst_sram_en;
      if (inst_sram_en) begin
        r_rdata <= w_inRange ? r_mem[w_idx] : INIT_VALUE;
        if (w_wrAllowed) begin
          for (int i = 0; i < 4; i++) begin
            if (inst_sram_wen[i]) begin
              r_mem[w_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
            end
          end
        end
      end
    end
  end

  assign inst_sram_rdata  = r_rdata;
  assign inst_sram_rvalid = r_rvalid;

endmodule
